if_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the program counter, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register. The ID stage consumes `Inst` and `PCPlus4`, and returns `Stall`, `Branch`, `Jump`, `BranchOffset` and `JumpAddress` to steer the next fetch. There is no branch delay slot: a redirect flushes the wrong-path fetch.

---
 rtl/if_stage.sv | 80 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of a five-stage MIPS pipeline.
// Holds the PC, drives the instruction-memory address and captures the
// fetched word into the IF/ID register. Redirects from ID flush the
// wrong-path fetch (no delay slot). Stall from ID freezes everything.
//
// Handshake: there is no valid/ready pair on memory; InstData is treated as
// combinationally valid for the current InstAddr every cycle. Towards ID,
// InstValid marks a real fetched word; it is low for inserted NOPs and ID
// applies back-pressure only through Stall, which holds the IF/ID contents.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpAddress,
  input  logic [31:0] InstData,
  output logic [31:0] InstAddr,
  output logic [31:0] Inst,
  output logic [31:0] PCPlus4,
  output logic        InstValid
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_pc_plus4;
  logic        r_inst_valid;

  logic [31:0] w_seq_pc;
  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;

  // Candidate next-PC values; branch/jump targets are relative to the
  // branch's own PC+4, which is the IF/ID copy, not the current fetch PC.
  always_comb begin
    w_seq_pc        = r_pc + 32'd4;
    w_branch_target = r_pc_plus4 + {BranchOffset[29:0], 2'b00};
    w_jump_target   = {r_pc_plus4[31:28], JumpAddress, 2'b00};
  end

  // Priority update: reset, stall (hold, ignores redirects), jump, branch, sequential.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc         <= RESET_PC;
      r_inst       <= NOP;
      r_pc_plus4   <= 32'd0;
      r_inst_valid <= 1'b0;
    end else if (Stall) begin
      r_pc         <= r_pc;
      r_inst       <= r_inst;
      r_pc_plus4   <= r_pc_plus4;
      r_inst_valid <= r_inst_valid;
    end else if (Jump) begin
      r_pc         <= w_jump_target;
      r_inst       <= NOP;
      r_pc_plus4   <= 32'd0;
      r_inst_valid <= 1'b0;
    end else if (Branch) begin
      r_pc         <= w_branch_target;
      r_inst       <= NOP;
      r_pc_plus4   <= 32'd0;
      r_inst_valid <= 1'b0;
    end else begin
      r_pc         <= w_seq_pc;
      r_inst       <= InstData;
      r_pc_plus4   <= w_seq_pc;
      r_inst_valid <= 1'b1;
    end
  end

  assign InstAddr  = r_pc;
  assign Inst      = r_inst;
  assign PCPlus4   = r_pc_plus4;
  assign InstValid = r_inst_valid;

endmodule
